swap_regfile: RTL and testbench
===============================

// Module: swap_regfile
// PURPOSE
// - Parametrised register file with a sequenced exchange engine: swaps or copies any two
//   entries through an internal temp register, one move per cycle.
// - Generalises the fixed three-register swap FSM to DEPTH entries of WIDTH bits.
// - Adds per-command operand selection, a copy mode, a host load/read port, a done/error
//   handshake and an operation counter.
// - Used by the datapath lab designs as a small scratch store driven by a controller FSM.
// PARAMETERS
// - WIDTH   6  bits per register entry
// - DEPTH   4  number of entries (2..16)
// - ADDR_W  2  index width, must satisfy 2**ADDR_W >= DEPTH
// - CNT_W   8  width of the completed-operation counter
// PORTS
// - ck        in   1       clock, all state updates on rising edge
// - rst       in   1       asynchronous, active-low reset
// - start     in   1       command request, sampled only in IDLE
// - op        in   1       0 = swap r[a]<->r[b], 1 = copy r[a]<=r[b]
// - sel_a     in   ADDR_W  operand A index
// - sel_b     in   ADDR_W  operand B index
// - wr_en     in   1       host write strobe, honoured only in IDLE
// - wr_addr   in   ADDR_W  host write index
// - wr_data   in   WIDTH   host write data
// - rd_addr   in   ADDR_W  host read index
// - rd_data   out  WIDTH   r[rd_addr], combinational; 0 if rd_addr >= DEPTH
// - busy      out  1       high while a command is in flight
// - done      out  1       one-cycle pulse after command completion
// - err       out  1       one-cycle pulse on rejected command
// - op_count  out  CNT_W   completed commands, saturating
// BEHAVIOUR
// - Reset (rst=0, async): r[i] = i+1 (truncated to WIDTH), tmp = 0, state = IDLE;
//   busy = 0, done = 0, err = 0, op_count = 0.
// - A reset asserted mid-operation abandons the command; no partial result survives.
// - States: IDLE, SAVE, MOVE, RESTORE.
// - IDLE, start=1, both indices < DEPTH:
//   - latch a, b, op; busy = 1 next cycle.
//   - next state is SAVE for swap, MOVE for copy.
// - IDLE, start=1, either index >= DEPTH:
//   - no register change, stay IDLE, err = 1 for one cycle, op_count unchanged.
// - SAVE: tmp <= r[b]; next MOVE.
// - MOVE:
//   - swap: r[b] <= r[a]; next RESTORE.
//   - copy: r[a] <= r[b]; next IDLE, done pulse.
// - RESTORE: r[a] <= tmp; next IDLE, done pulse.
// - Latency from the start-accept edge to the done-high cycle:
//   - swap: 3 edges; done high during the 4th cycle.
//   - copy: 1 edge; done high during the 2nd cycle.
// - busy falls in the same cycle done rises; a new start is accepted in that cycle.
// - Same-index commands (a == b) run the full sequence, leave data unchanged, and still
//   pulse done and count.
// - start and wr_en both high in IDLE: start wins, the write is dropped.
// - wr_en while busy is ignored.
// - Host write with wr_addr >= DEPTH is ignored, no err.
// - start while busy is ignored; the latched operands do not change mid-command.
// - op_count increments on each done pulse and saturates at 2**CNT_W-1.
// TESTING
// - Reset, read all indices -> rd_data = 1, 2, 3, 4; busy = 0, op_count = 0.
// - Swap a=0, b=3 -> done 3 edges after accept; r0=4, r3=1, others unchanged; op_count=1.
// - Copy a=2, b=1 -> done 1 edge after accept; r2=2, r1=2.
// - start with sel_a=5 at DEPTH=5/ADDR_W=3 -> err pulse; no change; op_count unchanged.
// - Reset at the RESTORE cycle of swap 1<->2 -> registers return to i+1, IDLE, done stays 0.
// - start+wr_en together, then wr_en while busy -> both writes dropped; back-to-back start
//   accepted in the done cycle.

Source files
------------

// File: rtl/swap_regfile.sv
// Register file with a sequenced swap/copy engine that moves one entry per cycle
// through a temp register; host load/read port, done/err pulses and a saturating op counter.
module swap_regfile #(
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] sel_a,
  input  logic [ADDR_W-1:0] sel_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {IDLE, SAVE, MOVE, RESTORE} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    r_q [DEPTH];
  logic [WIDTH-1:0]    r_d [DEPTH];
  logic [WIDTH-1:0]    tmp_q, tmp_d;
  logic [ADDR_W-1:0]   a_q, a_d, b_q, b_d;
  logic                op_q, op_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  function automatic logic in_range(input logic [ADDR_W-1:0] idx);
    return 32'(idx) < DEPTH;
  endfunction

  always_comb begin
    r_d     = r_q;
    tmp_d   = tmp_q;
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // A command takes priority over a simultaneous host write, which is dropped.
        if (start) begin
          if (in_range(sel_a) && in_range(sel_b)) begin
            a_d     = sel_a;
            b_d     = sel_b;
            op_d    = op;
            state_d = op ? MOVE : SAVE;
          end else begin
            err_d = 1'b1;
          end
        end else if (wr_en && in_range(wr_addr)) begin
          r_d[wr_addr] = wr_data;
        end
      end
      SAVE: begin
        tmp_d   = r_q[b_q];
        state_d = MOVE;
      end
      MOVE: begin
        if (op_q) begin
          r_d[a_q] = r_q[b_q];
          state_d  = IDLE;
          done_d   = 1'b1;
        end else begin
          r_d[b_q] = r_q[a_q];
          state_d  = RESTORE;
        end
      end
      RESTORE: begin
        r_d[a_q] = tmp_q;
        state_d  = IDLE;
        done_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (done_d && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_q[i] <= WIDTH'(i + 1);
      tmp_q   <= '0;
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      r_q     <= r_d;
      tmp_q   <= tmp_d;
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rd_data  = in_range(rd_addr) ? r_q[rd_addr] : '0;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign op_count = cnt_q;

endmodule

// File: tb/tb_swap_regfile.sv
// Directed bench for swap_regfile: a default instance plus a DEPTH=5/ADDR_W=3/CNT_W=2
// instance for out-of-range and counter saturation cases.
module tb_swap_regfile;

  logic ck = 1'b0;
  logic rst = 1'b0;
  always #5 ck = ~ck;

  logic       start0 = 0, op0 = 0, we0 = 0;
  logic [1:0] sa0 = 0, sb0 = 0, wa0 = 0, ra0 = 0;
  logic [5:0] wd0 = 0, rd0;
  logic       busy0, done0, err0;
  logic [7:0] cnt0;

  logic       start2 = 0, op2 = 0, we2 = 0;
  logic [2:0] sa2 = 0, sb2 = 0, wa2 = 0, ra2 = 0;
  logic [5:0] wd2 = 0, rd2;
  logic       busy2, done2, err2;
  logic [1:0] cnt2;

  swap_regfile dut0 (
    .ck(ck), .rst(rst), .start(start0), .op(op0), .sel_a(sa0), .sel_b(sb0),
    .wr_en(we0), .wr_addr(wa0), .wr_data(wd0), .rd_addr(ra0), .rd_data(rd0),
    .busy(busy0), .done(done0), .err(err0), .op_count(cnt0)
  );

  swap_regfile #(.WIDTH(6), .DEPTH(5), .ADDR_W(3), .CNT_W(2)) dut2 (
    .ck(ck), .rst(rst), .start(start2), .op(op2), .sel_a(sa2), .sel_b(sb2),
    .wr_en(we2), .wr_addr(wa2), .wr_data(wd2), .rd_addr(ra2), .rd_data(rd2),
    .busy(busy2), .done(done2), .err(err2), .op_count(cnt2)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [5:0]  m0[4];
  logic [5:0]  m2[8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic check_regs0(input string tag);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(m0[i]));
    for (int i = 0; i < 4; i++) begin
      ra0 = 2'(i);
      @(negedge ck);
      chk(tag, 32'(rd0), exp_q.pop_front());
    end
    tick();
  endtask

  task automatic check_regs2(input string tag);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(m2[i]));
    for (int i = 0; i < 8; i++) begin
      ra2 = 3'(i);
      @(negedge ck);
      chk(tag, 32'(rd2), exp_q.pop_front());
    end
    tick();
  endtask

  // Issue a command on dut0 in the current cycle, then measure edges to done.
  task automatic cmd0(input logic o, input logic [1:0] a, input logic [1:0] b);
    logic [5:0] t;
    int n;
    exp_q.push_back(o ? 32'd1 : 32'd3);
    start0 = 1; op0 = o; sa0 = a; sb0 = b;
    tick();
    start0 = 0;
    chk("busy0_after_accept", 32'(busy0), 32'd1);
    n = 0;
    while (!done0 && n < 20) begin
      tick();
      n++;
    end
    chk("latency0", 32'(n), exp_q.pop_front());
    chk("busy0_at_done", 32'(busy0), 32'd0);
    if (o) m0[a] = m0[b];
    else begin t = m0[a]; m0[a] = m0[b]; m0[b] = t; end
  endtask

  task automatic cmd2(input logic o, input logic [2:0] a, input logic [2:0] b);
    logic [5:0] t;
    int n;
    exp_q.push_back(o ? 32'd1 : 32'd3);
    start2 = 1; op2 = o; sa2 = a; sb2 = b;
    tick();
    start2 = 0;
    n = 0;
    while (!done2 && n < 20) begin
      tick();
      n++;
    end
    chk("latency2", 32'(n), exp_q.pop_front());
    if (o) m2[a] = m2[b];
    else begin t = m2[a]; m2[a] = m2[b]; m2[b] = t; end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m0[i] = 6'(i + 1);
    for (int i = 0; i < 8; i++) m2[i] = (i < 5) ? 6'(i + 1) : 6'd0;
    #12;
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_cnt", 32'(cnt0), 32'd0);
    rst = 1;
    tick();
    check_regs0("rst_regs");

    cmd0(1'b0, 2'd0, 2'd3);
    chk("cnt_after_swap", 32'(cnt0), 32'd1);
    check_regs0("swap03_regs");

    cmd0(1'b1, 2'd2, 2'd1);
    chk("cnt_after_copy", 32'(cnt0), 32'd2);
    check_regs0("copy21_regs");

    // start with simultaneous write, then a write while busy; both must be dropped
    exp_q.push_back(32'd3);
    start0 = 1; op0 = 0; sa0 = 0; sb0 = 1;
    we0 = 1; wa0 = 3; wd0 = 6'h3f;
    tick();
    start0 = 0; wa0 = 2; wd0 = 6'h15;
    begin
      int n;
      n = 0;
      while (!done0 && n < 20) begin
        tick();
        n++;
      end
      we0 = 0;
      chk("latency_wr_drop", 32'(n), exp_q.pop_front());
    end
    begin
      logic [5:0] t;
      t = m0[0]; m0[0] = m0[1]; m0[1] = t;
    end
    // back-to-back command in the done cycle
    cmd0(1'b1, 2'd3, 2'd0);
    chk("cnt_b2b", 32'(cnt0), 32'd4);
    check_regs0("wr_drop_regs");

    // same-index swap, with a different start presented while busy
    exp_q.push_back(32'd3);
    start0 = 1; op0 = 0; sa0 = 2; sb0 = 2;
    tick();
    op0 = 1; sa0 = 0; sb0 = 1;
    tick();
    start0 = 0;
    begin
      int n;
      n = 1;
      while (!done0 && n < 20) begin
        tick();
        n++;
      end
      chk("latency_same_idx", 32'(n), exp_q.pop_front());
    end
    chk("cnt_same_idx", 32'(cnt0), 32'd5);
    check_regs0("same_idx_regs");

    // host write at a valid index
    we0 = 1; wa0 = 1; wd0 = 6'h2a;
    tick();
    we0 = 0;
    m0[1] = 6'h2a;
    check_regs0("host_write_regs");

    // reset during RESTORE of swap 1<->2
    start0 = 1; op0 = 0; sa0 = 1; sb0 = 2;
    tick();
    start0 = 0;
    tick();
    tick();
    rst = 0;
    #2;
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_cnt", 32'(cnt0), 32'd0);
    @(negedge ck);
    rst = 1;
    for (int i = 0; i < 4; i++) m0[i] = 6'(i + 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge ck);
      chk("midrst_done", 32'(done0), 32'd0);
    end
    tick();
    check_regs0("midrst_regs");

    // out-of-range command on the DEPTH=5 instance
    start2 = 1; op2 = 0; sa2 = 5; sb2 = 1;
    tick();
    start2 = 0;
    chk("oor_err", 32'(err2), 32'd1);
    chk("oor_busy", 32'(busy2), 32'd0);
    tick();
    chk("oor_err_pulse", 32'(err2), 32'd0);
    chk("oor_cnt", 32'(cnt2), 32'd0);
    we2 = 1; wa2 = 7; wd2 = 6'h11;
    tick();
    we2 = 0;
    chk("oor_wr_err", 32'(err2), 32'd0);
    check_regs2("oor_regs");

    cmd2(1'b1, 3'd4, 3'd0);
    cmd2(1'b0, 3'd1, 3'd4);
    cmd2(1'b1, 3'd3, 3'd2);
    chk("cnt2_three", 32'(cnt2), 32'd3);
    cmd2(1'b1, 3'd0, 3'd3);
    chk("cnt2_saturate", 32'(cnt2), 32'd3);
    check_regs2("dut2_regs");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
